// File: rtl/cache_2way_wb_controller.sv
// cache_2way_wb_controller
//   Controller for a 2-way set-associative, write-back, write-allocate data cache
//   with one LRU bit per set. It owns the tag/valid/dirty/LRU state and the line
//   storage. It sequences the hit path, the dirty-victim writeback and the line
//   refill against a multi-cycle block memory that uses a req/ready handshake.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   cpu_req/rw/addr/wdata CPU request, sampled only while idle (rw: 0 read, 1 write)
//   cpu_rdata/ready/hit   completion pulse; rdata is the read word and is 0 when not ready;
//                         hit is 1 only if no refill was needed
//   mem_req/rw/addr       block transfer request, held until mem_ready (rw: 1 = writeback)
//   mem_wdata/mem_rdata   whole line; word w occupies bits [DATA_W*w +: DATA_W]
//   mem_ready             one-cycle transfer completion from memory
module cache_2way_wb_controller #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int BLOCK_WORDS = 4,
    parameter int SETS        = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cpu_req,
    input  logic                          cpu_rw,
    input  logic [ADDR_W-1:0]             cpu_addr,
    input  logic [DATA_W-1:0]             cpu_wdata,
    output logic [DATA_W-1:0]             cpu_rdata,
    output logic                          cpu_ready,
    output logic                          cpu_hit,
    output logic                          mem_req,
    output logic                          mem_rw,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [BLOCK_WORDS*DATA_W-1:0] mem_wdata,
    input  logic [BLOCK_WORDS*DATA_W-1:0] mem_rdata,
    input  logic                          mem_ready
);
    localparam int LINE_W = BLOCK_WORDS * DATA_W;
    localparam int BYTE_W = $clog2(DATA_W / 8);
    localparam int WORD_W = $clog2(BLOCK_WORDS);
    localparam int OFF_W  = BYTE_W + WORD_W;
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int DW_LOG = $clog2(DATA_W);

    typedef enum logic [1:0] {S_IDLE, S_COMPARE, S_WRITEBACK, S_ALLOCATE} state_t;
    state_t state_reg, state_next;

    // Latched request; miss_reg remembers that this request needed a refill.
    logic              req_rw_reg;
    logic [ADDR_W-1:0] req_addr_reg;
    logic [DATA_W-1:0] req_wdata_reg;
    logic              miss_reg;
    logic              victim_reg;

    // Per-way, per-set status bits. lru_reg holds the way to evict next.
    logic [1:0][SETS-1:0] valid_reg;
    logic [1:0][SETS-1:0] dirty_reg;
    logic [SETS-1:0]      lru_reg;

    // Line and tag storage, addressed by {way, set}. Not reset: valid bits guard them.
    logic [TAG_W-1:0]  tag_mem  [2*SETS];
    logic [LINE_W-1:0] data_mem [2*SETS];

    logic [TAG_W-1:0]            req_tag;
    logic [IDX_W-1:0]            req_idx;
    logic [WORD_W-1:0]           req_word;
    logic [WORD_W+DW_LOG-1:0]    word_lsb;
    logic [1:0]                  way_hit;
    logic [1:0][LINE_W-1:0]      way_line;
    logic                        hit;
    logic                        hit_way;
    logic [DATA_W-1:0]           hit_word;
    logic                        victim_sel;
    logic                        victim_dirty;
    logic [TAG_W-1:0]            victim_tag;
    logic [LINE_W-1:0]           victim_line;
    logic                        unused_addr_bits;

    assign req_tag  = req_addr_reg[ADDR_W-1 -: TAG_W];
    assign req_idx  = req_addr_reg[OFF_W +: IDX_W];
    assign req_word = req_addr_reg[BYTE_W +: WORD_W];
    assign word_lsb = {req_word, {DW_LOG{1'b0}}};
    // Byte offset within the word plays no part in word accesses.
    assign unused_addr_bits = ^req_addr_reg[BYTE_W-1:0];

    for (genvar gi = 0; gi < 2; gi++) begin : g_way
        localparam logic WAY = (gi == 1);
        assign way_line[gi] = data_mem[{WAY, req_idx}];
        assign way_hit[gi]  = valid_reg[gi][req_idx] && (tag_mem[{WAY, req_idx}] == req_tag);
    end

    // The two ways never hold the same tag, so way1's match alone names the hit way.
    assign hit      = |way_hit;
    assign hit_way  = way_hit[1];
    assign hit_word = way_line[hit_way][word_lsb +: DATA_W];

    // Fill an empty way first; only fall back to LRU when the set is full.
    assign victim_sel   = !valid_reg[0][req_idx] ? 1'b0 :
                          !valid_reg[1][req_idx] ? 1'b1 : lru_reg[req_idx];
    assign victim_dirty = valid_reg[victim_sel][req_idx] && dirty_reg[victim_sel][req_idx];
    assign victim_tag   = tag_mem[{victim_reg, req_idx}];
    assign victim_line  = data_mem[{victim_reg, req_idx}];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cpu_rdata  = '0;
        cpu_ready  = 1'b0;
        cpu_hit    = 1'b0;
        mem_req    = 1'b0;
        mem_rw     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_reg)
            S_IDLE: begin
                if (cpu_req) state_next = S_COMPARE;
            end
            S_COMPARE: begin
                if (hit) begin
                    cpu_ready  = 1'b1;
                    cpu_hit    = ~miss_reg;
                    if (!req_rw_reg) cpu_rdata = hit_word;
                    state_next = S_IDLE;
                end else begin
                    state_next = victim_dirty ? S_WRITEBACK : S_ALLOCATE;
                end
            end
            S_WRITEBACK: begin
                mem_req   = 1'b1;
                mem_rw    = 1'b1;
                mem_addr  = {victim_tag, req_idx, {OFF_W{1'b0}}};
                mem_wdata = victim_line;
                if (mem_ready) state_next = S_ALLOCATE;
            end
            S_ALLOCATE: begin
                mem_req  = 1'b1;
                mem_addr = {req_tag, req_idx, {OFF_W{1'b0}}};
                if (mem_ready) state_next = S_COMPARE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_rw_reg    <= 1'b0;
            req_addr_reg  <= '0;
            req_wdata_reg <= '0;
            miss_reg      <= 1'b0;
            victim_reg    <= 1'b0;
            valid_reg     <= '0;
            dirty_reg     <= '0;
            lru_reg       <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (cpu_req) begin
                        req_rw_reg    <= cpu_rw;
                        req_addr_reg  <= cpu_addr;
                        req_wdata_reg <= cpu_wdata;
                        miss_reg      <= 1'b0;
                    end
                end
                S_COMPARE: begin
                    if (hit) begin
                        lru_reg[req_idx] <= ~hit_way;
                        if (req_rw_reg) dirty_reg[hit_way][req_idx] <= 1'b1;
                    end else begin
                        miss_reg   <= 1'b1;
                        victim_reg <= victim_sel;
                    end
                end
                S_WRITEBACK: begin
                    if (mem_ready) dirty_reg[victim_reg][req_idx] <= 1'b0;
                end
                S_ALLOCATE: begin
                    if (mem_ready) begin
                        valid_reg[victim_reg][req_idx] <= 1'b1;
                        dirty_reg[victim_reg][req_idx] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage writes: word update on a write hit, whole-line refill on allocate.
    always_ff @(posedge clk) begin
        if (state_reg == S_COMPARE && hit && req_rw_reg) begin
            data_mem[{hit_way, req_idx}][word_lsb +: DATA_W] <= req_wdata_reg;
        end
        if (state_reg == S_ALLOCATE && mem_ready) begin
            data_mem[{victim_reg, req_idx}] <= mem_rdata;
            tag_mem[{victim_reg, req_idx}]  <= req_tag;
        end
    end
endmodule

// File: tb/tb_cache_2way_wb_controller.sv
// Bench for cache_2way_wb_controller: directed scenarios followed by random traffic.
// The reference keeps the CPU-visible memory image, the backing memory image and
// the cache residency (tag, valid, dirty, LRU per set and way) at transaction level.
module tb_cache_2way_wb_controller;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cpu_req = 1'b0;
    logic         cpu_rw = 1'b0;
    logic [9:0]   cpu_addr = '0;
    logic [31:0]  cpu_wdata = '0;
    logic [31:0]  cpu_rdata;
    logic         cpu_ready;
    logic         cpu_hit;
    logic         mem_req;
    logic         mem_rw;
    logic [9:0]   mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata = '0;
    logic         mem_ready;
    logic         resp_ready = 1'b0;
    logic         force_ready = 1'b0;

    assign mem_ready = resp_ready | force_ready;

    cache_2way_wb_controller dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_rw    (cpu_rw),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .cpu_hit   (cpu_hit),
        .mem_req   (mem_req),
        .mem_rw    (mem_rw),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Backing memory seen by the bus, plus the reference images.
    logic [7:0]  mem_bytes   [1024];
    logic [31:0] ref_backing [256];
    logic [31:0] cpu_view    [256];

    // Reference cache residency.
    bit          m_valid [2][4];
    bit          m_dirty [2][4];
    logic [3:0]  m_tag   [2][4];
    bit          m_lru   [4];

    // Completed memory transfers.
    bit           xq_rw   [$];
    logic [9:0]   xq_addr [$];
    logic [127:0] xq_data [$];
    int           resp_cnt = 0;

    // Memory slave: answers 3 cycles after mem_req is seen, one block per transfer.
    always @(negedge clk) begin
        if (resp_ready) begin
            resp_ready = 1'b0;
            resp_cnt   = 0;
        end
        if (mem_req) begin
            resp_cnt++;
            if (resp_cnt == 3) begin
                for (int b = 0; b < 16; b++) begin
                    if (mem_rw) mem_bytes[int'({mem_addr[9:4], 4'b0000}) + b] = mem_wdata[8*b +: 8];
                    else        mem_rdata[8*b +: 8] = mem_bytes[int'({mem_addr[9:4], 4'b0000}) + b];
                end
                xq_rw.push_back(mem_rw);
                xq_addr.push_back(mem_addr);
                xq_data.push_back(mem_wdata);
                resp_ready = 1'b1;
            end
        end else begin
            resp_cnt = 0;
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < 2; w++)
            for (int s = 0; s < 4; s++) begin
                m_valid[w][s] = 1'b0;
                m_dirty[w][s] = 1'b0;
            end
        for (int s = 0; s < 4; s++) m_lru[s] = 1'b0;
        for (int i = 0; i < 256; i++) cpu_view[i] = ref_backing[i];
    endtask

    // mode 0: plain request; 1: assert reset once a writeback starts;
    // 2: pulse a second cpu_req while the refill is in progress.
    task automatic do_req(input bit rw, input logic [9:0] addr, input logic [31:0] wd, input int mode);
        int idx, tag, wi, hw, victim, vb, cycles, exp_lat, exp_nx;
        bit exp_hit, exp_wb, aborted, pulsed;
        logic [9:0]   exp_wb_addr, exp_al_addr;
        logic [127:0] exp_wb_line;
        idx = int'(addr[5:4]);
        tag = int'(addr[9:6]);
        wi  = int'(addr[9:2]);
        hw  = -1;
        for (int w = 0; w < 2; w++)
            if (m_valid[w][idx] && int'(m_tag[w][idx]) == tag) hw = w;
        exp_hit = (hw >= 0);
        victim  = !m_valid[0][idx] ? 0 : (!m_valid[1][idx] ? 1 : int'(m_lru[idx]));
        exp_wb  = !exp_hit && m_valid[victim][idx] && m_dirty[victim][idx];
        vb      = int'(m_tag[victim][idx]) * 16 + idx * 4;
        exp_wb_addr = 10'(vb * 4);
        exp_al_addr = {addr[9:4], 4'b0000};
        for (int k = 0; k < 4; k++) exp_wb_line[32*k +: 32] = cpu_view[(vb + k) % 256];
        exp_lat = exp_hit ? 1 : (exp_wb ? 8 : 5);
        exp_nx  = exp_hit ? 0 : (exp_wb ? 2 : 1);
        aborted = 1'b0;
        pulsed  = 1'b0;
        xq_rw.delete(); xq_addr.delete(); xq_data.delete();

        @(negedge clk);
        cpu_req = 1'b1; cpu_rw = rw; cpu_addr = addr; cpu_wdata = wd;
        @(negedge clk);
        cpu_req = 1'b0;
        cycles  = 1;
        while (!cpu_ready && cycles < 60 && !aborted) begin
            if (mode == 1 && mem_req && mem_rw) begin
                #2 reset = 1'b1;
                #1;
                check("rst_mem_req_drop", 128'(mem_req), 128'(0));
                check("rst_mem_addr", 128'(mem_addr), 128'(0));
                @(negedge clk);
                reset = 1'b0;
                model_reset();
                aborted = 1'b1;
            end else begin
                if (mode == 2 && !pulsed && mem_req && !mem_rw) begin
                    cpu_req = 1'b1; cpu_rw = ~rw; cpu_addr = addr ^ 10'h3C0;
                    pulsed = 1'b1;
                end else begin
                    cpu_req = 1'b0;
                end
                @(negedge clk);
                cycles++;
            end
        end
        cpu_req = 1'b0;

        if (mode == 1) begin
            check("wb_reached_for_reset", 128'(aborted), 128'(1));
            $display("TXN %s addr=%03h aborted_by_reset=%0b cycles=%0d", rw ? "WR" : "RD", addr, aborted, cycles);
        end else begin
            if (mode == 2) check("alloc_pulse_done", 128'(pulsed), 128'(1));
            $display("TXN %s addr=%03h wdata=%08h rdata=%08h hit=%0b cycles=%0d xfers=%0d",
                     rw ? "WR" : "RD", addr, wd, cpu_rdata, cpu_hit, cycles, xq_rw.size());
            check("ready_seen", 128'(cpu_ready), 128'(1));
            check("latency", 128'(cycles), 128'(exp_lat));
            check("cpu_hit", 128'(cpu_hit), 128'(exp_hit));
            if (!rw) check("rdata", 128'(cpu_rdata), 128'(cpu_view[wi]));
            check("xfer_count", 128'(xq_rw.size()), 128'(exp_nx));
            if (exp_wb && xq_rw.size() >= 1) begin
                check("wb_rw", 128'(xq_rw[0]), 128'(1));
                check("wb_addr", 128'(xq_addr[0]), 128'(exp_wb_addr));
                check("wb_data", xq_data[0], exp_wb_line);
            end
            if (!exp_hit && xq_rw.size() == exp_nx) begin
                check("alloc_rw", 128'(xq_rw[exp_nx-1]), 128'(0));
                check("alloc_addr", 128'(xq_addr[exp_nx-1]), 128'(exp_al_addr));
            end
            @(negedge clk);
            check("ready_single_pulse", 128'(cpu_ready), 128'(0));
            check("rdata_zero_idle", 128'(cpu_rdata), 128'(0));

            // Reference update for the completed request.
            if (!exp_hit) begin
                if (exp_wb)
                    for (int k = 0; k < 4; k++) ref_backing[vb + k] = cpu_view[vb + k];
                m_tag[victim][idx]   = 4'(tag);
                m_valid[victim][idx] = 1'b1;
                m_dirty[victim][idx] = 1'b0;
                hw = victim;
            end
            m_lru[idx] = (hw == 0);
            if (rw) begin
                m_dirty[hw][idx] = 1'b1;
                cpu_view[wi] = wd;
            end
        end
    endtask

    initial begin
        int bad;
        logic [31:0] wd;
        for (int w = 0; w < 256; w++) begin
            wd = (w < 4) ? 32'h0 : $urandom;
            for (int b = 0; b < 4; b++) mem_bytes[4*w + b] = wd[8*b +: 8];
            ref_backing[w] = wd;
        end
        model_reset();

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_cpu_ready", 128'(cpu_ready), 128'(0));
        check("reset_cpu_hit", 128'(cpu_hit), 128'(0));
        check("reset_cpu_rdata", 128'(cpu_rdata), 128'(0));
        check("reset_mem_req", 128'(mem_req), 128'(0));
        check("reset_mem_rw", 128'(mem_rw), 128'(0));
        check("reset_mem_addr", 128'(mem_addr), 128'(0));
        check("reset_mem_wdata", mem_wdata, 128'(0));
        reset = 1'b0;

        // Cold read miss, write hit, read-back hit.
        do_req(1'b0, 10'h000, 32'h0, 0);
        do_req(1'b1, 10'h000, 32'h0000_00FF, 0);
        do_req(1'b0, 10'h000, 32'h0, 0);
        check("byte0_not_written_through", 128'(mem_bytes[0]), 128'(8'h00));

        // Second way fill, hit on first way, clean eviction, dirty eviction.
        do_req(1'b0, 10'h200, 32'h0, 0);
        do_req(1'b0, 10'h000, 32'h0, 0);
        do_req(1'b0, 10'h300, 32'h0, 0);
        do_req(1'b0, 10'h200, 32'h0, 0);
        check("byte0_after_writeback", 128'(mem_bytes[0]), 128'(8'hFF));

        // Make both ways dirty, then reset in the middle of the writeback.
        do_req(1'b1, 10'h304, $urandom, 0);
        do_req(1'b1, 10'h208, $urandom, 0);
        do_req(1'b0, 10'h100, 32'h0, 1);
        do_req(1'b0, 10'h000, 32'h0, 0);

        // Stray cpu_req during refill, then mem_ready held high while idle.
        do_req(1'b0, 10'h100, 32'h0, 2);
        xq_rw.delete(); xq_addr.delete(); xq_data.delete();
        force_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("idle_ready_no_req", 128'(mem_req), 128'(0));
            check("idle_ready_no_cpu", 128'(cpu_ready), 128'(0));
        end
        force_ready = 1'b0;
        check("idle_ready_no_xfer", 128'(xq_rw.size()), 128'(0));
        do_req(1'b0, 10'h104, 32'h0, 0);

        // Random traffic over a few tags so sets keep conflicting.
        repeat (40) begin
            logic [9:0] a;
            a = {4'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            do_req(1'($urandom_range(0, 1)), a, $urandom, 0);
        end

        bad = 0;
        for (int w = 0; w < 256; w++)
            if ({mem_bytes[4*w+3], mem_bytes[4*w+2], mem_bytes[4*w+1], mem_bytes[4*w]} !== ref_backing[w]) bad++;
        check("memory_image_words_wrong", 128'(bad), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
